// File: rtl/r2n_pkg.sv
// Shared sizing and index helpers for the ready-to-normal buffer and its normal-to-ready counterpart.
package r2n_pkg;

   // Core count per matrix width.
   function automatic int r2n_num_cores(input int col);
      case (col)
         2754:    return 9;
         256:     return 8;
         200:     return 5;
         64:      return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int r2n_beats(input int col, input int block_size, input int num_cores);
      return col / (block_size * num_cores);
   endfunction

   function automatic int r2n_stripes(input int row, input int block_size);
      return row / block_size;
   endfunction

   // Column within a stripe of element j of block column bc.
   function automatic int r2n_col_idx(input int bc, input int block_size, input int j);
      return bc * block_size + j;
   endfunction

   function automatic int r2n_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/r2n_bank.sv
// One BLOCK_SIZE x COL tile-reassembly bank: a whole input beat is written per cycle, one row read.
module r2n_bank
   import r2n_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int COL        = 256,
   parameter int NUM_CORES  = 8,
   localparam int BEATS     = r2n_beats(COL, BLOCK_SIZE, NUM_CORES),
   localparam int BW        = r2n_cnt_width(BEATS),
   localparam int RW        = r2n_cnt_width(BLOCK_SIZE),
   localparam int IN_W      = WIDTH * CHUNK_SIZE * NUM_CORES,
   localparam int OUT_W     = WIDTH * COL
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [BW-1:0]    wr_beat,
   input  logic [IN_W-1:0]  wr_data,
   input  logic [RW-1:0]    rd_row,
   output logic [OUT_W-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [BLOCK_SIZE][COL];
   logic [WIDTH-1:0] mem_d [BLOCK_SIZE][COL];

   // Beat index is matched against constants so every write target is a fixed location.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         for (int b = 0; b < BEATS; b++) begin
            if (wr_beat == BW'(b)) begin
               for (int k = 0; k < NUM_CORES; k++) begin
                  for (int i = 0; i < BLOCK_SIZE; i++) begin
                     for (int j = 0; j < BLOCK_SIZE; j++) begin
                        mem_d[i][r2n_col_idx(b * NUM_CORES + k, BLOCK_SIZE, j)] =
                           wr_data[(k * CHUNK_SIZE + i * BLOCK_SIZE + j) * WIDTH +: WIDTH];
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data = '0;
      for (int r = 0; r < BLOCK_SIZE; r++) begin
         if (rd_row == RW'(r)) begin
            for (int c = 0; c < COL; c++) begin
               rd_data[c * WIDTH +: WIDTH] = mem_q[r][c];
            end
         end
      end
   end

endmodule

// File: rtl/r2n_buffer.sv
// Ready-to-normal buffer: collects block-ordered tile beats into ping-pong banks and emits full matrix rows.
module r2n_buffer
   import r2n_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int ROW        = 2754,
   parameter int COL        = 256,
   parameter int NUM_CORES  = r2n_num_cores(COL)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_r2n_buffer,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [WIDTH*COL-1:0]                  out_r2n_buffer,
   output logic                                  out_last,
   output logic                                  slice_done
);

   localparam int BEATS   = r2n_beats(COL, BLOCK_SIZE, NUM_CORES);
   localparam int STRIPES = r2n_stripes(ROW, BLOCK_SIZE);
   localparam int BW      = r2n_cnt_width(BEATS);
   localparam int RW      = r2n_cnt_width(BLOCK_SIZE);
   localparam int SW      = r2n_cnt_width(STRIPES);
   localparam int OUT_W   = WIDTH * COL;

   if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_bad_chunk
      $error("r2n_buffer: CHUNK_SIZE must equal BLOCK_SIZE squared");
   end
   if ((ROW % BLOCK_SIZE) != 0) begin : g_bad_row
      $error("r2n_buffer: ROW must be a multiple of BLOCK_SIZE");
   end
   if ((COL % (BLOCK_SIZE * NUM_CORES)) != 0) begin : g_bad_col
      $error("r2n_buffer: COL must be a multiple of BLOCK_SIZE*NUM_CORES");
   end
   if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
      $error("r2n_buffer: FRAC_WIDTH exceeds WIDTH");
   end

   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [RW-1:0] rd_row_q, rd_row_d;
   logic [SW-1:0] stripe_q, stripe_d;
   logic [1:0]    full_q, full_d;
   logic          slice_done_q, slice_done_d;

   logic             in_fire, out_fire, last_row, last_stripe;
   logic [OUT_W-1:0] bank_rd [2];

   assign in_ready    = ~full_q[wr_bank_q];
   assign out_valid   = full_q[rd_bank_q];
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready;
   assign last_row    = (rd_row_q == RW'(BLOCK_SIZE - 1));
   assign last_stripe = (stripe_q == SW'(STRIPES - 1));

   assign out_last       = out_valid & last_row & last_stripe;
   assign slice_done     = slice_done_q;
   assign out_r2n_buffer = out_valid ? bank_rd[rd_bank_q] : '0;

   for (genvar g = 0; g < 2; g++) begin : g_bank
      r2n_bank #(
         .WIDTH      (WIDTH),
         .BLOCK_SIZE (BLOCK_SIZE),
         .CHUNK_SIZE (CHUNK_SIZE),
         .COL        (COL),
         .NUM_CORES  (NUM_CORES)
      ) u_bank (
         .clk     (clk),
         .wr_en   (in_fire & (wr_bank_q == 1'(g))),
         .wr_beat (beat_q),
         .wr_data (in_r2n_buffer),
         .rd_row  (rd_row_q),
         .rd_data (bank_rd[g])
      );
   end

   // Write and read always target different banks, so both updates may land on one edge.
   always_comb begin
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      beat_d       = beat_q;
      rd_row_d     = rd_row_q;
      stripe_d     = stripe_q;
      full_d       = full_q;
      slice_done_d = 1'b0;
      if (in_fire) begin
         if (beat_q == BW'(BEATS - 1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            beat_d            = '0;
         end else begin
            beat_d = beat_q + BW'(1);
         end
      end
      if (out_fire) begin
         if (last_row) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_row_d          = '0;
            slice_done_d      = 1'b1;
            stripe_d          = last_stripe ? '0 : stripe_q + SW'(1);
         end else begin
            rd_row_d = rd_row_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         beat_q       <= '0;
         rd_row_q     <= '0;
         stripe_q     <= '0;
         full_q       <= '0;
         slice_done_q <= 1'b0;
      end else begin
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         beat_q       <= beat_d;
         rd_row_q     <= rd_row_d;
         stripe_q     <= stripe_d;
         full_q       <= full_d;
         slice_done_q <= slice_done_d;
      end
   end

endmodule

// File: tb/tb_r2n_buffer.sv
// Bench for r2n_buffer: matrix-level row model with a per-cycle compare process plus directed literal checks.
module tb_r2n_buffer;

   localparam int W     = 16;
   localparam int BS    = 2;
   localparam int CS    = 4;
   localparam int COLS  = 8;
   localparam int NC    = 2;
   localparam int ROWS  = 4;
   localparam int BEATS = COLS / (BS * NC);
   localparam int IN_W  = W * CS * NC;
   localparam int OUT_W = W * COLS;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             last;
      int               r;
   } row_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic             out_last;
   logic             slice_done;

   int   nvec = 0;
   int   nerr = 0;
   int   last_cnt = 0;
   int   slice_cnt = 0;
   int   stall_cnt = 0;
   bit   rand_ready = 1'b0;
   bit   exp_slice = 1'b0;
   row_t exp_q[$];

   always #5 clk = ~clk;

   r2n_buffer #(
      .WIDTH      (W),
      .FRAC_WIDTH (8),
      .BLOCK_SIZE (BS),
      .CHUNK_SIZE (CS),
      .ROW        (ROWS),
      .COL        (COLS),
      .NUM_CORES  (NC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_r2n_buffer  (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_r2n_buffer (out_data),
      .out_last       (out_last),
      .slice_done     (slice_done)
   );

   // Matrix m element (r,c); the offset keeps successive matrices distinct.
   function automatic logic [W-1:0] elem(input int m, input int r, input int c);
      return W'(m * 32 + r * COLS + c);
   endfunction

   function automatic logic [OUT_W-1:0] row_val(input int m, input int r);
      logic [OUT_W-1:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++) v[c*W +: W] = elem(m, r, c);
      return v;
   endfunction

   // Tile-ordered beat as the MAC array delivers it.
   function automatic logic [IN_W-1:0] beat_data(input int m, input int s, input int b);
      logic [IN_W-1:0] d;
      d = '0;
      for (int k = 0; k < NC; k++)
         for (int i = 0; i < BS; i++)
            for (int j = 0; j < BS; j++)
               d[(k*CS + i*BS + j)*W +: W] = elem(m, s*BS + i, (b*NC + k)*BS + j);
      return d;
   endfunction

   task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_stripe(input int m, input int s);
      for (int i = 0; i < BS; i++) begin
         row_t e;
         e.data = row_val(m, s*BS + i);
         e.last = ((s*BS + i) == ROWS - 1);
         e.r    = s*BS + i;
         exp_q.push_back(e);
      end
   endtask

   task automatic send_beat(input int m, input int s, input int b, input int max_gap);
      bit acc;
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = beat_data(m, s, b);
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
         stall_cnt++;
      end
      nvec++;
      nerr++;
      $display("FAIL beat_accept_timeout: got no accept expected accept m=%0d s=%0d b=%0d", m, s, b);
      in_valid = 1'b0;
   endtask

   task automatic send_stripe(input int m, input int s, input int max_gap);
      push_stripe(m, s);
      for (int b = 0; b < BEATS; b++) send_beat(m, s, b, max_gap);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 500; t++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_pending_rows", exp_q.size(), 0);
      @(posedge clk); #1;
      check("drain_out_valid", out_valid, 1'b0);
   endtask

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Compare process: every cycle, the visible row must be the oldest expected row.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_slice = 1'b0;
      end else begin
         check("slice_done", slice_done, exp_slice);
         if (slice_done) slice_cnt++;
         exp_slice = 1'b0;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_row: got %h expected no row", out_data);
            end else begin
               check("row_data", out_data, exp_q[0].data);
               check("out_last", out_last, exp_q[0].last);
               if (out_ready) begin
                  if (out_last) last_cnt++;
                  exp_slice = ((exp_q[0].r % BS) == BS - 1);
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            check("idle_data", out_data, '0);
            check("idle_last", out_last, 1'b0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_slice_done", slice_done, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic reorder: stripe 0 of matrix 0.
      out_ready = 1'b1;
      slice_cnt = 0;
      send_stripe(0, 0, 0);
      check("latency_valid", out_valid, 1'b1);
      check("row0_literal", out_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      @(posedge clk); #1;
      check("row1_literal", out_data, 128'h000f_000e_000d_000c_000b_000a_0009_0008);
      check("row1_not_last", out_last, 1'b0);
      @(posedge clk); #1;
      check("slice_pulse", slice_done, 1'b1);
      check("empty_after_stripe", out_valid, 1'b0);
      @(posedge clk); #1;
      check("slice_pulse_count", slice_cnt, 1);

      // Full matrix: stripe 1 carries the last row.
      send_stripe(0, 1, 0);
      check("row2_literal", out_data, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
      @(posedge clk); #1;
      check("row3_literal", out_data, 128'h001f_001e_001d_001c_001b_001a_0019_0018);
      check("row3_last", out_last, 1'b1);
      wait_drain();

      // Concurrent write/read with continuous input.
      stall_cnt = 0;
      send_stripe(1, 0, 0);
      send_stripe(1, 1, 0);
      send_stripe(2, 0, 0);
      send_stripe(2, 1, 0);
      check("stream_no_stall", stall_cnt, 0);
      wait_drain();

      // Backpressure: both banks fill, then drain.
      out_ready = 1'b0;
      send_stripe(3, 0, 0);
      send_stripe(3, 1, 0);
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         check("bp_in_ready_low", in_ready, 1'b0);
         check("bp_out_valid", out_valid, 1'b1);
      end
      push_stripe(4, 0);
      in_valid  = 1'b1;
      in_data   = beat_data(4, 0, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_still_low", in_ready, 1'b0);
      @(posedge clk); #1;
      check("bp_ready_back", in_ready, 1'b1);
      send_beat(4, 0, 0, 0);
      send_beat(4, 0, 1, 0);
      send_stripe(4, 1, 0);
      wait_drain();

      // Reset mid-stripe.
      out_ready = 1'b0;
      send_stripe(5, 0, 0);
      send_beat(5, 1, 0, 0);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, '0);
      check("midrst_out_last", out_last, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send_stripe(6, 0, 0);
      check("post_rst_row0", out_data, 128'h00c7_00c6_00c5_00c4_00c3_00c2_00c1_00c0);
      send_stripe(6, 1, 0);
      wait_drain();

      // Idle gaps on both sides over ten matrices.
      last_cnt   = 0;
      rand_ready = 1'b1;
      for (int m = 7; m < 17; m++) begin
         send_stripe(m, 0, 2);
         send_stripe(m, 1, 2);
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain();
      check("last_count", last_cnt, 10);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
